skeleton_sequencer: RTL and testbench

Controller that sequences a single skeleton core (echo or model skeleton) for a host-driven test run. It accepts a burst of input words from the host-side stream, feeds each word to the skeleton with one START pulse, waits for the skeleton's DATA_VALID (with timeout) and returns the result on an output stream. It sits between the host interface (UART/SPI bridge) and the skeleton, and latches the skeleton header once per run.

---
 rtl/skeleton_sequencer.sv | 173 +++++++++++++++++
 tb/tb_skeleton_sequencer.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/skeleton_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : skeleton_sequencer
// Purpose  : Runs one skeleton core (echo or model) for a host-driven test.
//            Takes a burst of CMD_LEN words from the host input stream. For
//            each word it pulses START once and waits for DATA_VALID, with a
//            timeout. It returns each result on the output stream. The
//            skeleton header is latched once per run.
// Ports    : CLK_SYS / nRST         clock, async active-low reset
//            CMD_START/ABORT/LEN    run control from the host bridge
//            IN_*                   host input stream (valid/ready)
//            OUT_*                  result output stream (valid/ready)
//            SKL_*                  skeleton core interface
//            HEAD_REG               header captured at run start
//            BUSY/DONE/ERR_TIMEOUT  status; WORD_CNT words completed
// Revision : 1.0 - initial release
// ============================================================================
module skeleton_sequencer #(
  parameter int BITWIDTH_SYS  = 16,
  parameter int BITWIDTH_HEAD = 32,
  parameter int LEN_BITS      = 16,
  parameter int TIMEOUT       = 1024
) (
  input  logic                     CLK_SYS,
  input  logic                     nRST,
  input  logic                     CMD_START,
  input  logic                     CMD_ABORT,
  input  logic [LEN_BITS-1:0]      CMD_LEN,
  input  logic [BITWIDTH_SYS-1:0]  IN_DATA,
  input  logic                     IN_VALID,
  output logic                     IN_READY,
  output logic [BITWIDTH_SYS-1:0]  OUT_DATA,
  output logic                     OUT_VALID,
  input  logic                     OUT_READY,
  output logic                     SKL_EN,
  output logic                     SKL_START,
  output logic [BITWIDTH_SYS-1:0]  SKL_DATA_IN,
  input  logic [BITWIDTH_SYS-1:0]  SKL_DATA_OUT,
  input  logic [BITWIDTH_HEAD-7:0] SKL_DATA_HEAD,
  input  logic                     SKL_DATA_VALID,
  output logic [BITWIDTH_HEAD-7:0] HEAD_REG,
  output logic                     BUSY,
  output logic                     DONE,
  output logic                     ERR_TIMEOUT,
  output logic [LEN_BITS-1:0]      WORD_CNT
);

  localparam int c_CNT_W = $clog2(TIMEOUT) + 1;
  // Counter value whose arrival ends the wait. Because of it, the timeout
  // flag is visible exactly TIMEOUT cycles after the START cycle.
  localparam logic [c_CNT_W-1:0] c_TMO_LAST = c_CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HEAD  = 3'd1,
    S_LOAD  = 3'd2,
    S_START = 3'd3,
    S_WAIT  = 3'd4,
    S_OUT   = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t                     r_state;
  state_t                     w_next;
  logic                       w_timeout;
  logic [LEN_BITS-1:0]        r_len;
  logic [LEN_BITS-1:0]        r_word_cnt;
  logic [LEN_BITS-1:0]        w_wcnt_inc;
  logic [c_CNT_W-1:0]         r_cnt;
  logic [c_CNT_W-1:0]         w_cnt_inc;
  logic [BITWIDTH_SYS-1:0]    r_skl_din;
  logic [BITWIDTH_SYS-1:0]    r_out_data;
  logic [BITWIDTH_HEAD-7:0]   r_head;
  logic                       r_err;

  assign w_cnt_inc  = r_cnt + c_CNT_W'(1);
  assign w_wcnt_inc = r_word_cnt + LEN_BITS'(1);

  // State register
  always_ff @(posedge CLK_SYS or negedge nRST) begin
    if (!nRST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next    = r_state;
    w_timeout = 1'b0;
    case (r_state)
      S_IDLE:  if (CMD_START) w_next = S_HEAD;
      S_HEAD:  w_next = (r_len == '0) ? S_DONE : S_LOAD;
      S_LOAD:  if (IN_VALID) w_next = S_START;
      S_START: w_next = S_WAIT;
      S_WAIT: begin
        // A valid result wins over a timeout in the same cycle.
        if (SKL_DATA_VALID) begin
          w_next = S_OUT;
        end else if (w_cnt_inc == c_TMO_LAST) begin
          w_timeout = 1'b1;
          w_next    = S_IDLE;
        end
      end
      S_OUT: begin
        if (OUT_READY) w_next = (w_wcnt_inc == r_len) ? S_DONE : S_LOAD;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    // Abort overrides everything, including a coincident START in IDLE.
    if (CMD_ABORT) begin
      w_next    = S_IDLE;
      w_timeout = 1'b0;
    end
  end

  // Datapath registers. During an abort cycle they all hold, so WORD_CNT,
  // HEAD_REG and the error flag keep what the interrupted run left.
  always_ff @(posedge CLK_SYS or negedge nRST) begin
    if (!nRST) begin
      r_len      <= '0;
      r_word_cnt <= '0;
      r_cnt      <= '0;
      r_skl_din  <= '0;
      r_out_data <= '0;
      r_head     <= '0;
      r_err      <= 1'b0;
    end else if (!CMD_ABORT) begin
      case (r_state)
        S_IDLE: begin
          if (CMD_START) begin
            r_len      <= CMD_LEN;
            r_word_cnt <= '0;
            r_err      <= 1'b0;
          end
        end
        S_HEAD:  r_head <= SKL_DATA_HEAD;
        S_LOAD:  if (IN_VALID) r_skl_din <= IN_DATA;
        S_START: r_cnt <= '0;
        S_WAIT: begin
          if (SKL_DATA_VALID) begin
            r_out_data <= SKL_DATA_OUT;
          end else if (w_timeout) begin
            r_err <= 1'b1;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        S_OUT:   if (OUT_READY) r_word_cnt <= w_wcnt_inc;
        default: ;
      endcase
    end
  end

  // Control outputs are decoded from the state register only. LOAD keeps
  // SKL_EN low, which clears the skeleton's run state between words.
  assign SKL_EN      = (r_state == S_HEAD) || (r_state == S_START) ||
                       (r_state == S_WAIT) || (r_state == S_OUT);
  assign SKL_START   = (r_state == S_START);
  assign IN_READY    = (r_state == S_LOAD);
  assign OUT_VALID   = (r_state == S_OUT);
  assign BUSY        = (r_state != S_IDLE);
  assign DONE        = (r_state == S_DONE);
  assign ERR_TIMEOUT = r_err;
  assign WORD_CNT    = r_word_cnt;
  assign HEAD_REG    = r_head;
  assign OUT_DATA    = r_out_data;
  assign SKL_DATA_IN = r_skl_din;

endmodule
`default_nettype wire

// File: tb/tb_skeleton_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_skeleton_sequencer
// Purpose  : Scoreboard bench for skeleton_sequencer. It uses an echo
//            skeleton stub, which can be muted to force a timeout.
// Revision : 1.0 - initial release
// ============================================================================
module tb_skeleton_sequencer;

  localparam int TMO = 16;
  localparam logic [25:0] ECHO_HEAD = {4'd0, 6'd1, 6'd1, 5'd16, 5'd16};

  logic        CLK_SYS = 1'b0;
  logic        nRST = 1'b0;
  logic        CMD_START = 1'b0;
  logic        CMD_ABORT = 1'b0;
  logic [15:0] CMD_LEN = '0;
  logic [15:0] IN_DATA = '0;
  logic        IN_VALID = 1'b0;
  logic        IN_READY;
  logic [15:0] OUT_DATA;
  logic        OUT_VALID;
  logic        OUT_READY = 1'b1;
  logic        SKL_EN;
  logic        SKL_START;
  logic [15:0] SKL_DATA_IN;
  logic [15:0] stub_data = '0;
  logic        stub_valid = 1'b0;
  logic        stub_mute = 1'b0;
  logic [25:0] HEAD_REG;
  logic        BUSY;
  logic        DONE;
  logic        ERR_TIMEOUT;
  logic [15:0] WORD_CNT;

  skeleton_sequencer #(
    .BITWIDTH_SYS(16), .BITWIDTH_HEAD(32), .LEN_BITS(16), .TIMEOUT(TMO)
  ) dut (
    .CLK_SYS(CLK_SYS), .nRST(nRST),
    .CMD_START(CMD_START), .CMD_ABORT(CMD_ABORT), .CMD_LEN(CMD_LEN),
    .IN_DATA(IN_DATA), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .OUT_DATA(OUT_DATA), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .SKL_EN(SKL_EN), .SKL_START(SKL_START), .SKL_DATA_IN(SKL_DATA_IN),
    .SKL_DATA_OUT(stub_data), .SKL_DATA_HEAD(ECHO_HEAD),
    .SKL_DATA_VALID(stub_valid),
    .HEAD_REG(HEAD_REG), .BUSY(BUSY), .DONE(DONE),
    .ERR_TIMEOUT(ERR_TIMEOUT), .WORD_CNT(WORD_CNT)
  );

  always #5 CLK_SYS = ~CLK_SYS;

  // Echo skeleton: DATA_VALID comes one cycle after an enabled START pulse.
  always @(posedge CLK_SYS) begin
    stub_valid <= SKL_EN && SKL_START && !stub_mute;
    stub_data  <= SKL_DATA_IN;
  end

  int cyc = 0;
  always @(posedge CLK_SYS) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] in_q[$];
  logic [15:0] exp_q[$];
  int done_cnt = 0;
  int done_cyc = 0;
  int start_cyc = 0;
  int cyc_start = 0;
  bit in_ready_seen = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual 0x%0h required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Feeder: presents the head of in_q. It pops when a handshake is certain
  // at the coming edge, because IN_READY is stable between clock edges.
  initial forever begin
    @(negedge CLK_SYS);
    if (in_q.size() > 0) begin
      IN_VALID = 1'b1;
      IN_DATA  = in_q[0];
      if (IN_READY) void'(in_q.pop_front());
    end else begin
      IN_VALID = 1'b0;
    end
  end

  // Monitor: samples just before the active edge and scores output
  // transfers against the expected queue.
  initial forever begin
    @(negedge CLK_SYS);
    #4;
    if (DONE) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (IN_READY) in_ready_seen = 1'b1;
    if (SKL_START) start_cyc = cyc;
    if (OUT_VALID && OUT_READY) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL out_extra: actual 0x%0h required no output", OUT_DATA);
      end else begin
        check("out_data", {16'h0, OUT_DATA}, {16'h0, exp_q.pop_front()});
      end
    end
  end

  task automatic start_run(input int len);
    @(negedge CLK_SYS);
    CMD_LEN   = 16'(len);
    CMD_START = 1'b1;
    @(negedge CLK_SYS);
    cyc_start = cyc;   // edge that sampled CMD_START
    CMD_START = 1'b0;
  endtask

  task automatic wait_done(input int d0, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge CLK_SYS);
      if (done_cnt > d0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Standard echo run. DONE is the (2+4N+1)th cycle counted from the
  // CMD_START cycle inclusive.
  task automatic run_echo();
    int d0;
    bit ok;
    in_q.push_back(16'h1234); exp_q.push_back(16'h1234);
    in_q.push_back(16'hABCD); exp_q.push_back(16'hABCD);
    in_q.push_back(16'h0001); exp_q.push_back(16'h0001);
    d0 = done_cnt;
    start_run(3);
    wait_done(d0, ok);
    check("echo_done_seen", ok, 1);
    check("echo_done_cycles", done_cyc - cyc_start + 2, 2 + 4*3 + 1);
    check("echo_word_cnt", WORD_CNT, 3);
    check("echo_head_reg", HEAD_REG, ECHO_HEAD);
    check("echo_all_out", exp_q.size(), 0);
    check("echo_busy_after", BUSY, 0);
    repeat (3) @(negedge CLK_SYS);
    check("echo_one_done", done_cnt, d0 + 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    bit ok;
    bit found;
    int err_cyc;

    // Reset state
    repeat (3) @(negedge CLK_SYS);
    check("rst_busy", BUSY, 0);
    check("rst_skl_en", SKL_EN, 0);
    check("rst_in_ready", IN_READY, 0);
    check("rst_out_valid", OUT_VALID, 0);
    check("rst_err", ERR_TIMEOUT, 0);
    check("rst_word_cnt", WORD_CNT, 0);
    check("rst_head", HEAD_REG, 0);
    nRST = 1'b1;
    repeat (2) @(negedge CLK_SYS);

    // 1) Echo run
    run_echo();

    // 2) Backpressure on word 2
    in_q.push_back(16'h1111); exp_q.push_back(16'h1111);
    in_q.push_back(16'h2222); exp_q.push_back(16'h2222);
    in_q.push_back(16'h3333); exp_q.push_back(16'h3333);
    d0 = done_cnt;
    start_run(3);
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (OUT_VALID && WORD_CNT == 16'd1) begin
        found = 1'b1;
        break;
      end
      @(negedge CLK_SYS);
    end
    check("bp_reach_word2", found, 1);
    OUT_READY = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK_SYS);
      check("bp_out_valid", OUT_VALID, 1);
      check("bp_out_data", OUT_DATA, 16'h2222);
      check("bp_in_ready", IN_READY, 0);
    end
    OUT_READY = 1'b1;
    wait_done(d0, ok);
    check("bp_done_seen", ok, 1);
    check("bp_all_out", exp_q.size(), 0);
    check("bp_word_cnt", WORD_CNT, 3);

    // 3) Timeout with a muted skeleton
    stub_mute = 1'b1;
    in_q.push_back(16'h7777);
    d0 = done_cnt;
    start_run(1);
    found = 1'b0;
    err_cyc = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge CLK_SYS);
      if (ERR_TIMEOUT) begin
        found = 1'b1;
        err_cyc = cyc;
        break;
      end
    end
    check("tmo_flag", found, 1);
    check("tmo_latency", err_cyc - start_cyc, TMO);
    check("tmo_busy", BUSY, 0);
    repeat (2) @(negedge CLK_SYS);
    check("tmo_no_done", done_cnt, d0);
    stub_mute = 1'b0;

    // 4) Zero-length run; also clears the sticky timeout flag
    in_ready_seen = 1'b0;
    d0 = done_cnt;
    start_run(0);
    check("len0_err_cleared", ERR_TIMEOUT, 0);
    wait_done(d0, ok);
    check("len0_done_seen", ok, 1);
    check("len0_done_cycles", done_cyc - cyc_start + 2, 3);
    check("len0_no_in_ready", in_ready_seen, 0);
    check("len0_word_cnt", WORD_CNT, 0);

    // 5) Abort during WAIT of word 2
    in_q.push_back(16'h4444); exp_q.push_back(16'h4444);
    in_q.push_back(16'h5555); exp_q.push_back(16'h5555);
    in_q.push_back(16'h6666); exp_q.push_back(16'h6666);
    d0 = done_cnt;
    start_run(3);
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (SKL_EN && !SKL_START && !OUT_VALID && WORD_CNT == 16'd1) begin
        found = 1'b1;
        break;
      end
      @(negedge CLK_SYS);
    end
    check("abort_reach_wait2", found, 1);
    CMD_ABORT = 1'b1;
    @(negedge CLK_SYS);
    CMD_ABORT = 1'b0;
    check("abort_busy", BUSY, 0);
    check("abort_skl_en", SKL_EN, 0);
    check("abort_out_valid", OUT_VALID, 0);
    check("abort_word_cnt", WORD_CNT, 1);
    repeat (3) @(negedge CLK_SYS);
    check("abort_no_done", done_cnt, d0);
    check("abort_pending_out", exp_q.size(), 2);
    exp_q.delete();
    in_q.delete();
    @(negedge CLK_SYS);

    // 6) Reset while in OUT, then a fresh echo run
    OUT_READY = 1'b0;
    in_q.push_back(16'h9999);
    in_q.push_back(16'h8888);
    start_run(2);
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (OUT_VALID) begin
        found = 1'b1;
        break;
      end
      @(negedge CLK_SYS);
    end
    check("rstmid_reach_out", found, 1);
    #1 nRST = 1'b0;
    #1;
    check("rstmid_out_valid", OUT_VALID, 0);
    check("rstmid_busy", BUSY, 0);
    check("rstmid_skl_en", SKL_EN, 0);
    check("rstmid_out_data", OUT_DATA, 0);
    check("rstmid_skl_din", SKL_DATA_IN, 0);
    check("rstmid_head", HEAD_REG, 0);
    check("rstmid_word_cnt", WORD_CNT, 0);
    in_q.delete();
    exp_q.delete();
    @(negedge CLK_SYS);
    nRST = 1'b1;
    OUT_READY = 1'b1;
    @(negedge CLK_SYS);
    run_echo();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
